// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared widths, state encoding and constants for the sequential divider
package seq_divider_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;
  localparam logic [DIV_WIDTH-1:0] DZ_QUOT = '1;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;
endpackage

// File: rtl/seq_divider_sub.sv
// sub_n: N-bit subtractor a + ~b + 1 built on a plain adder, borrow = no carry out
module sub_n #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  logic carry;
  assign {carry, diff} = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
  assign borrow = ~carry;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring 32-bit divider, one subtract-and-shift step per clock
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  state_t st, nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_w, quo_w, dmag, orig;
  logic sa, sb, dz, borrow;
  logic [WIDTH:0] r_sh, diff;
  logic diff_msb_unused;
  // The shifted partial remainder needs one extra bit; a successful subtract always clears it.
  assign r_sh = {rem_w, quo_w[WIDTH-1]};
  assign diff_msb_unused = diff[WIDTH];
  sub_n #(.N(WIDTH+1)) u_sub (
    .a(r_sh),
    .b({1'b0, dmag}),
    .diff(diff),
    .borrow(borrow)
  );
  // State register
  always_ff @(posedge clk) st <= !rst_n ? IDLE : nx;
  // Next-state decode and busy flag
  always_comb begin
    nx = IDLE;
    busy = 1'b0;
    busy = st != IDLE;
    nx = st == IDLE ? (start ? (divisor == '0 ? FIX : RUN) : IDLE) :
         st == RUN  ? (cnt == CNT_W'(WIDTH-1) ? FIX : RUN) : IDLE;
  end
  // Operand latch, iteration datapath and result sign fix-up
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      rem_w <= '0;
      quo_w <= '0;
      dmag <= '0;
      orig <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      dz <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          sa <= is_signed & dividend[WIDTH-1];
          sb <= is_signed & divisor[WIDTH-1];
          quo_w <= (is_signed & dividend[WIDTH-1]) ? ~dividend + WIDTH'(1) : dividend;
          dmag <= (is_signed & divisor[WIDTH-1]) ? ~divisor + WIDTH'(1) : divisor;
          rem_w <= '0;
          cnt <= '0;
          dz <= divisor == '0;
          orig <= dividend;
        end
        RUN: begin
          rem_w <= borrow ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          quo_w <= {quo_w[WIDTH-2:0], ~borrow};
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          done <= 1'b1;
          div_by_zero <= dz;
          quotient <= dz ? DZ_QUOT : ((sa ^ sb) ? ~quo_w + WIDTH'(1) : quo_w);
          remainder <= dz ? orig : (sa ? ~rem_w + WIDTH'(1) : rem_w);
        end
        default: ;
      endcase
    end
  end
endmodule
